// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the lane/strobe/extension helpers used by lsu_align.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Stores accept B/H/W only; loads additionally accept BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  // Halfwords use only off[1] and words ignore the offset, which silently
  // aligns misaligned accesses down.
  function automatic logic [3:0] gen_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << {off[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] r;
    case (f3[1:0])
      2'b00: begin
        sh = rd >> {off, 3'b000};
        r  = f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = rd >> {off[1], 4'b0000};
        r  = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = rd;
        r  = sh;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_if_align.sv
// Combinational lane logic: store strobe/replication from the incoming
// request, load shift/extension from the latched request and bus data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [3:0]  st_strb_o,
  output logic [31:0] st_wdata_o,
  output logic [31:0] ld_data_o
);

  // Pure lane steering; no state.
  always_comb begin
    st_strb_o  = gen_strb(st_funct3_i, st_off_i);
    st_wdata_o = rep_wdata(st_funct3_i, st_wdata_i);
    ld_data_o  = ext_load(ld_funct3_i, ld_off_i, ld_rdata_i);
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit bus adapter: turns one core load/store into a word-aligned
// req/gnt/rvalid transaction with byte strobes, stalling the core meanwhile.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault without a bus
// access; otherwise the low address bits are forced to zero.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_bad;
  logic        busy_q;
  logic        complete;
  logic        tmo;
  logic        to_hit;
  logic        ld_cap;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  lsu_align u_align (
    .st_funct3_i (core_funct3),
    .st_off_i    (core_addr[1:0]),
    .st_wdata_i  (core_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata),
    .st_strb_o   (st_strb),
    .st_wdata_o  (st_wdata),
    .ld_data_o   (ld_data)
  );

  // Request legality check, with the optional misalignment fault.
  always_comb begin
    req_bad = !f3_legal(core_we, core_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = req_bad || f3_misaligned(core_funct3, core_addr[1:0]);
`endif
  end

  // Next state; a completing bus beat wins over the watchdog in the last cycle.
  always_comb begin
    state_d  = state_q;
    busy_q   = (state_q == REQ) || (state_q == WAIT);
    tmo      = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    complete = ((state_q == REQ) && mem_gnt && (we_q || mem_rvalid)) ||
               ((state_q == WAIT) && mem_rvalid);
    ld_cap   = !we_q && complete;
    to_hit   = busy_q && tmo && !complete;
    case (state_q)
      IDLE: if (core_req) state_d = req_bad ? DONE : REQ;
      REQ: begin
        if (complete || to_hit) state_d = DONE;
        else if (mem_gnt)       state_d = WAIT;
      end
      WAIT: if (complete || to_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (busy_q && ((state_d == REQ) || (state_d == WAIT))) ? cnt_q + 1'b1 : '0;
  end

  // State, watchdog, latched request and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == IDLE) && core_req) begin
        we_q        <= core_we;
        f3_q        <= core_funct3;
        off_q       <= core_addr[1:0];
        mem_we_q    <= core_we;
        mem_addr_q  <= {core_addr[31:2], 2'b00};
        mem_wstrb_q <= core_we ? st_strb : 4'b0000;
        mem_wdata_q <= core_we ? st_wdata : '0;
        rdata_q     <= '0;
        err_q       <= req_bad;
      end
      if (ld_cap) rdata_q <= ld_data;
      if (to_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Outputs; stall is combinational so the core freezes in the request cycle.
  always_comb begin
    core_stall = ((state_q == IDLE) && core_req) || (state_q == REQ) || (state_q == WAIT);
    core_done  = (state_q == DONE);
    core_err   = core_done && err_q;
    core_rdata = core_done ? rdata_q : '0;
    mem_req    = (state_q == REQ);
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wstrb  = mem_wstrb_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: transaction-level timing/data model,
// one negedge compare process, directed cases plus random traffic.
module tb_lsu_mem_if;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_done, core_err;
  logic [31:0] core_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_done, e_err, e_mreq, e_mwe, chk_rd, chk_wd;
  logic [31:0] e_rdata, e_maddr, e_wdata;
  logic [3:0]  e_wstrb;

  lsu_mem_if #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_done(core_done),
    .core_rdata(core_rdata), .core_err(core_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (arithmetic) ----------------
  function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] a);
    int unsigned o;
    o = a % 4;
    case (f3 % 4)
      0:       return o;
      1:       return (o / 2) * 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] rd);
    int unsigned o;
    logic [31:0] v;
    o = m_off(f3, a);
    case (f3 % 4)
      0: begin
        v = (rd >> (8 * o)) % 256;
        if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
      end
      1: begin
        v = (rd >> (8 * o)) % 65536;
        if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned o;
    o = m_off(f3, a);
    case (f3 % 4)
      0:       return 4'(1 << o);
      1:       return 4'(3 << o);
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3 % 4)
      0:       return (wd % 256) * 32'h01010101;
      1:       return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic m_ok(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    ok = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 % 4 == 1 && a % 2 != 0) || (f3 % 4 == 2 && a % 4 != 0)) ok = 1'b0;
`else
    if (a == 32'hFFFFFFFF) ok = ok;
`endif
    return ok;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(core_stall), 32'(e_stall));
      check("done",  32'(core_done),  32'(e_done));
      check("mreq",  32'(mem_req),    32'(e_mreq));
      if (e_done) check("err", 32'(core_err), 32'(e_err));
      if (chk_rd) check("rdata", core_rdata, e_rdata);
      if (e_mreq) begin
        check("mwe",   32'(mem_we),    32'(e_mwe));
        check("maddr", mem_addr,       e_maddr);
        check("wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (chk_wd) check("mwdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      @(posedge clk); #1;
      core_req   = 1'b0;
      mem_gnt    = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      e_stall = 1'b0; e_done = 1'b0; e_mreq = 1'b0; chk_rd = 1'b0;
      chk_en  = 1'b1;
    end
  endtask

  // g = REQ cycles before gnt, r = cycles from gnt to rvalid.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int unsigned g, input int unsigned r);
    logic ok, tmo;
    int unsigned n, dc, mend;
    ok = m_ok(we, f3, addr);
    tmo = 1'b0; mend = 0; dc = 1;
    if (ok) begin
      n    = we ? g + 1 : g + 1 + r;
      tmo  = (n > TO);
      dc   = tmo ? TO + 1 : 1 + n;
      mend = (g + 1 < TO) ? g + 1 : TO;
    end
    for (int unsigned c = 0; c <= dc; c++) begin
      @(posedge clk); #1;
      core_req    = (c < dc) ? 1'b1 : 1'($urandom_range(0, 1));
      core_we     = we;
      core_funct3 = f3;
      core_addr   = addr;
      core_wdata  = wdata;
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = $urandom;
      if (ok && c >= 1 && c < dc) begin
        if (c == 1 + g) mem_gnt = 1'b1;
        if (!we && c == 1 + g + r) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end
      end else if (c == 0 || c == dc) begin
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
      end
      e_stall = (c < dc);
      e_done  = (c == dc);
      e_err   = !ok || tmo;
      chk_rd  = (c == dc) && (tmo || (ok && !we));
      e_rdata = tmo ? 32'h0 : m_ext(f3, addr, rdata);
      e_mreq  = ok && c >= 1 && c <= mend;
      e_mwe   = we;
      e_maddr = addr & ~32'h3;
      e_wstrb = we ? m_strb(f3, addr) : 4'b0000;
      e_wdata = m_wdata(f3, wdata);
      chk_wd  = we;
      chk_en  = 1'b1;
    end
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010;
    core_addr = 32'h00004000; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    e_stall = 1'b1; e_done = 1'b0; e_mreq = 1'b0; chk_rd = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    e_mreq = 1'b1; e_mwe = 1'b0; e_maddr = 32'h00004000; e_wstrb = 4'b0000; chk_wd = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    e_mreq = 1'b0;
    @(posedge clk); #1;
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    core_req = 1'b0;
    #1;
    check("rst_stall", 32'(core_stall), 32'h0);
    check("rst_done",  32'(core_done),  32'h0);
    check("rst_err",   32'(core_err),   32'h0);
    check("rst_rdata", core_rdata,      32'h0);
    check("rst_mreq",  32'(mem_req),    32'h0);
    check("rst_mwe",   32'(mem_we),     32'h0);
    check("rst_maddr", mem_addr,        32'h0);
    check("rst_wstrb", 32'(mem_wstrb),  32'h0);
    check("rst_wdata", mem_wdata,       32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      core_req = 1'b0; mem_rvalid = 1'b1; mem_gnt = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      e_stall = 1'b0; e_done = 1'b0; e_mreq = 1'b0; chk_rd = 1'b0;
      chk_en = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_funct3 = '0;
    core_addr = '0; core_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    check("reset_stall", 32'(core_stall), 32'h0);
    check("reset_done",  32'(core_done),  32'h0);
    check("reset_mreq",  32'(mem_req),    32'h0);
    check("reset_rdata", core_rdata,      32'h0);
    #10 rst_n = 1'b1;

    // model pins from hand-computed values
    check("pin_sb_strb",  32'(m_strb(3'b000, 32'h00001003)), 32'h8);
    check("pin_sb_wdata", m_wdata(3'b000, 32'h000000A5), 32'hA5A5A5A5);
    check("pin_lb",  m_ext(3'b000, 32'h00002002, 32'h12803456), 32'hFFFFFF80);
    check("pin_lbu", m_ext(3'b100, 32'h00002002, 32'h12803456), 32'h00000080);
    check("pin_lh",  m_ext(3'b001, 32'h00002002, 32'h80011234), 32'hFFFF8001);

    idle(2);
    run_txn(1'b1, 3'b000, 32'h00001003, 32'h000000A5, 32'h0, 0, 0);
    idle(1);
    run_txn(1'b0, 3'b000, 32'h00002002, 32'h0, 32'h12803456, 0, 0);
    run_txn(1'b0, 3'b100, 32'h00002002, 32'h0, 32'h12803456, 0, 0);
    run_txn(1'b0, 3'b001, 32'h00002002, 32'h0, 32'h80011234, 0, 0);
    idle(1);
    run_txn(1'b0, 3'b010, 32'h00003000, 32'h0, 32'hCAFEF00D, 10, 5);
    idle(2);
    run_txn(1'b0, 3'b010, 32'h00003004, 32'h0, 32'h11111111, TO + 5, 0);
    idle(2);
    run_txn(1'b0, 3'b011, 32'h00001000, 32'h0, 32'h0, 0, 0);
    idle(1);
    run_txn(1'b0, 3'b010, 32'h00001002, 32'h0, 32'h89ABCDEF, 1, 1);
    run_txn(1'b1, 3'b001, 32'h00001003, 32'h0000BEEF, 32'h0, 0, 0);
    idle(1);
    reset_in_wait();

    for (int i = 0; i < 150; i++) begin
      int unsigned g, r;
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, g, r);
      idle($urandom_range(0, 2));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit: the responder end of the decoder's mem_we / funct3 / load-writeback interface.
- Takes one load or store request per instruction from the datapath.
- Converts it into a word-aligned request/grant/response transaction on the data-memory bus, with byte strobes.
- Returns aligned, sign- or zero-extended load data, and stalls the core until the access completes.

Parameters:
- TIMEOUT_CYC, 255: bus watchdog limit, in cycles spent in REQ+WAIT before aborting; legal range 1..65535.
- CNT_W, 16: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  load/store request; held stable by the core while core_stall=1.
- core_we  in  1  1=store, 0=load (from decoder mem_we).
- core_funct3  in  3  access size/sign (decoder funct3).
- core_addr  in  32  byte address (ALU result).
- core_wdata  in  32  store data (rs2).
- core_stall  out  1  freeze PC/pipeline.
- core_done  out  1  one-cycle completion pulse.
- core_rdata  out  32  extended load data; valid while core_done=1.
- core_err  out  1  access fault; valid while core_done=1.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_wstrb  out  4  byte-lane enables; 0000 for reads.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; watchdog=0; latched request cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If core_req=1, latch we/funct3/addr/wdata and compute strobes.
  - Illegal funct3 (loads 011/110/111; stores 1xx/011) -> DONE with err=1 and no bus access.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_wstrb/mem_wdata are registered and held stable until mem_gnt.
  - Store with gnt -> DONE.
  - Load with gnt and rvalid in the same cycle -> DONE.
  - Load with gnt only -> WAIT.
- WAIT: mem_req=0; on rvalid, capture the extracted data -> DONE.
- DONE: core_done=1 for exactly one cycle, then IDLE. core_req is ignored in DONE, because the core advances that cycle.
- core_stall (combinational): 1 when (IDLE and core_req) or state is REQ or WAIT; 0 in DONE and in idle-without-request.
- Minimum latency, core_req to core_done:
  - 2 cycles for a store or a same-cycle gnt+rvalid load.
  - 3 cycles when rvalid arrives one cycle after gnt.
- Watchdog:
  - Counts every cycle in REQ or WAIT and clears on leaving them.
  - When the count reaches TIMEOUT_CYC: mem_req drops, go to DONE with err=1 and rdata=0.
- Store strobes:
  - SB: 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: 0011<<{addr[1],1'b0}, wdata = {2{half}}.
  - SW: 1111.
- Load extraction:
  - Shift mem_rdata right by 8*addr[1:0] (byte) or 16*addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Stale bus responses: rvalid/gnt arriving in IDLE or DONE are ignored.
- Reset mid-transaction: the transaction is abandoned; no completion pulse is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, goes from IDLE straight to DONE with err=1.
  - No bus access is made.
- Undefined:
  - The offending low address bits are silently forced to 0 (LH at 0x..3 accesses 0x..2; LW ignores addr[1:0]).
  - core_err is asserted only for illegal funct3 or watchdog timeout.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the state enum (IDLE/REQ/WAIT/DONE);
  - the strobe-generation and extension functions.
- Sub-module lsu_align (purely combinational):
  - store lane replication and strobe generation;
  - load shift and extension;
  - instantiated once.
- FSM and watchdog stay in lsu_mem_if.

Test Plan:
1. SB addr=0x00001003 wdata=0x000000A5, gnt in first REQ cycle -> mem_addr=0x00001000, mem_wstrb=1000, mem_wdata=0xA5A5A5A5, core_done on cycle 2, err=0.
2. LB addr=0x00002002, rdata=0x12803456 -> core_rdata=0xFFFFFF80; same access as LBU -> 0x00000080; LH addr=0x00002002, rdata=0x80011234 -> 0xFFFF8001.
3. LW with gnt held low 10 cycles, rvalid 5 cycles after gnt -> core_stall=1 throughout; mem_req high for exactly the 11 REQ cycles; single core_done pulse; rdata equals the word.
4. TIMEOUT_CYC=8, gnt never asserted -> after 8 REQ cycles mem_req=0, core_done=1, core_err=1, core_rdata=0.
5. funct3=011 load -> no mem_req ever; core_done+core_err one cycle after core_req. With LSU_MISALIGN_TRAP_EN: LW at 0x00001002 -> err, no mem_req. Without it: mem_addr=0x00001000.
6. rst_n pulled low in WAIT -> all outputs 0 immediately; rvalid arriving after reset release -> ignored, no core_done.
